// File: rtl/countdown_ctrl.sv
// Countdown controller: start/pause key handling, tick prescaler, and digit-counter strobes for a two-digit BCD timer.
// Latency: key rise seen on a clock edge, state and outputs change at the following edge; all outputs registered.
// Backpressure: none; keys are level inputs edge-detected internally, tick suppressed by start/pause is dropped.
// Optional feature: define COUNTDOWN_WARN_EN to drive the low-time warn indicator; otherwise warn is tied 0.
module countdown_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    output logic       load_n,
    output logic       ones_en_cnt,
    output logic       tens_en_cnt,
    output logic       running,
    output logic       paused,
    output logic       timeout,
    output logic       expired_pulse,
    output logic       warn
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_EXPIRED = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          start_hist_q, start_hist_d;
    logic          pause_hist_q, pause_hist_d;
    logic          load_n_q, load_n_d;
    logic          ones_en_q, ones_en_d;
    logic          tens_en_q, tens_en_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;
    logic          timeout_q, timeout_d;
    logic          exp_pulse_q, exp_pulse_d;

    logic          start_req;
    logic          pause_req;
    logic          tick;
    logic          ones_zero;
    logic          digits_zero;

    // Key rise detection against the previous cycle's key level.
    always_comb begin
        start_hist_d = start_key;
        pause_hist_d = pause_key;
        start_req    = start_key & ~start_hist_q;
        pause_req    = pause_key & ~pause_hist_q;
    end

    // Tick is the prescaler wrap cycle; any nonzero code (including non-BCD) counts as "not zero".
    always_comb begin
        tick        = (presc_q == PRESC_LAST);
        ones_zero   = (ones == 4'd0);
        digits_zero = ones_zero && (tens == 4'd0);
    end

    // Next-state, prescaler and digit strobes; start beats pause beats tick, and a lost tick is not replayed.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ones_en_d = 1'b0;
        tens_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (start_req) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                presc_d = '0;
                state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (start_req) begin
                    state_d = S_LOAD;
                    presc_d = '0;
                end else if (pause_req) begin
                    // Prescaler freezes at its current value so the resumed second is not shortened.
                    state_d = S_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    if (digits_zero) begin
                        state_d = S_EXPIRED;
                    end else begin
                        ones_en_d = 1'b1;
                        tens_en_d = ones_zero;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSED: begin
                if (start_req) begin
                    state_d = S_LOAD;
                    presc_d = '0;
                end else if (pause_req) begin
                    state_d = S_RUNNING;
                end
            end
            S_EXPIRED: begin
                presc_d = '0;
                if (start_req) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
            end
        endcase
    end

    // Status outputs are registered decodes of the next state so they line up with state_q.
    always_comb begin
        load_n_d    = (state_d != S_LOAD);
        running_d   = (state_d == S_RUNNING);
        paused_d    = (state_d == S_PAUSED);
        timeout_d   = (state_d == S_EXPIRED);
        exp_pulse_d = (state_d == S_EXPIRED) && (state_q != S_EXPIRED);
    end

    // State, prescaler, key history and registered outputs; reset abandons any count in progress.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            start_hist_q <= 1'b0;
            pause_hist_q <= 1'b0;
            load_n_q     <= 1'b1;
            ones_en_q    <= 1'b0;
            tens_en_q    <= 1'b0;
            running_q    <= 1'b0;
            paused_q     <= 1'b0;
            timeout_q    <= 1'b0;
            exp_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            start_hist_q <= start_hist_d;
            pause_hist_q <= pause_hist_d;
            load_n_q     <= load_n_d;
            ones_en_q    <= ones_en_d;
            tens_en_q    <= tens_en_d;
            running_q    <= running_d;
            paused_q     <= paused_d;
            timeout_q    <= timeout_d;
            exp_pulse_q  <= exp_pulse_d;
        end
    end

`ifdef COUNTDOWN_WARN_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

    logic warn_q, warn_d;

    // Warn is steady while paused in the last ten seconds and blinks at tick rate while running there.
    always_comb begin
        warn_d = 1'b0;
        if (tens == 4'd0) begin
            if (state_d == S_PAUSED) begin
                warn_d = 1'b1;
            end else if (state_d == S_RUNNING) begin
                warn_d = (presc_d < PRESC_HALF);
            end
        end
    end

    // Warn register, aligned with the prescaler value it was derived from.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

    assign load_n        = load_n_q;
    assign ones_en_cnt   = ones_en_q;
    assign tens_en_cnt   = tens_en_q;
    assign running       = running_q;
    assign paused        = paused_q;
    assign timeout       = timeout_q;
    assign expired_pulse = exp_pulse_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl at TICK_DIV=4: cycle-by-cycle vector table plus pause, start-hold and reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit after each rising edge.
// Expected warn values follow the build: COUNTDOWN_WARN_EN selects the blink model, otherwise warn must stay 0.
module tb_countdown_ctrl;

`ifdef COUNTDOWN_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       start_key, pause_key;
    logic [3:0] ones, tens;
    logic       load_n, ones_en_cnt, tens_en_cnt;
    logic       running, paused, timeout, expired_pulse, warn;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_ctrl #(.TICK_DIV(4)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .start_key    (start_key),
        .pause_key    (pause_key),
        .ones         (ones),
        .tens         (tens),
        .load_n       (load_n),
        .ones_en_cnt  (ones_en_cnt),
        .tens_en_cnt  (tens_en_cnt),
        .running      (running),
        .paused       (paused),
        .timeout      (timeout),
        .expired_pulse(expired_pulse),
        .warn         (warn)
    );

    always #5 clk = ~clk;

    // Expected bits: {load_n, ones_en, tens_en, running, paused, timeout, expired_pulse, warn_if_enabled}
    typedef struct packed {
        logic       sk;
        logic       pk;
        logic [3:0] o;
        logic [3:0] t;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sk, input logic pk, input logic [3:0] o,
                                input logic [3:0] t, input logic [7:0] exp);
        vec_t v;
        v.sk  = sk;
        v.pk  = pk;
        v.o   = o;
        v.t   = t;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {load_n, ones_en_cnt, tens_en_cnt, running, paused, timeout, expired_pulse, warn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic sk, input logic pk, input logic [3:0] o, input logic [3:0] t);
        @(negedge clk);
        start_key = sk;
        pause_key = pk;
        ones      = o;
        tens      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   first_en;
        int   loads;
        logic saw_paused;

        resetN    = 1'b0;
        start_key = 1'b0;
        pause_key = 1'b0;
        ones      = 4'd0;
        tens      = 4'd2;

        // IDLE -> LOAD -> RUNNING; ticks with tens/ones 2/0, 1/9, 1/0; warn blink with 0/5; expiry; restart; pause.
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd2, 8'b1000_0000)); // 0  idle
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 4'd2, 8'b0000_0000)); // 1  start rise -> LOAD
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 4'd2, 8'b1001_0000)); // 2  RUNNING, presc 0
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd2, 8'b1001_0000)); // 3  presc 1
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd2, 8'b1001_0000)); // 4  presc 2
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd2, 8'b1001_0000)); // 5  presc 3
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd2, 8'b1111_0000)); // 6  tick, ones 0 -> borrow
        tbl.push_back(mk(1'b0, 1'b0, 4'd9, 4'd1, 8'b1001_0000)); // 7
        tbl.push_back(mk(1'b0, 1'b0, 4'd9, 4'd1, 8'b1001_0000)); // 8
        tbl.push_back(mk(1'b0, 1'b0, 4'd9, 4'd1, 8'b1001_0000)); // 9
        tbl.push_back(mk(1'b0, 1'b0, 4'd9, 4'd1, 8'b1101_0000)); // 10 tick, ones only
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd1, 8'b1001_0000)); // 11
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd1, 8'b1001_0000)); // 12
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd1, 8'b1001_0000)); // 13
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd1, 8'b1111_0000)); // 14 tick 1/0 -> both enables
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0001)); // 15 presc 1, warn on
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0000)); // 16 presc 2, warn off
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0000)); // 17 presc 3
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1101_0001)); // 18 tick, presc 0, warn on
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0001)); // 19 presc 1
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0000)); // 20 presc 2
        tbl.push_back(mk(1'b0, 1'b0, 4'd5, 4'd0, 8'b1001_0000)); // 21 presc 3
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 8'b1000_0110)); // 22 tick at 0/0 -> EXPIRED
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 8'b1000_0100)); // 23 timeout held, pulse gone
        tbl.push_back(mk(1'b0, 1'b1, 4'd0, 4'd0, 8'b1000_0100)); // 24 pause ignored
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 8'b1000_0100)); // 25
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 8'b0000_0000)); // 26 restart -> LOAD
        tbl.push_back(mk(1'b0, 1'b0, 4'd3, 4'd4, 8'b1001_0000)); // 27 presc 0
        tbl.push_back(mk(1'b0, 1'b0, 4'd3, 4'd4, 8'b1001_0000)); // 28 presc 1
        tbl.push_back(mk(1'b0, 1'b0, 4'd3, 4'd4, 8'b1001_0000)); // 29 presc 2
        tbl.push_back(mk(1'b0, 1'b1, 4'd3, 4'd4, 8'b1000_1000)); // 30 pause at presc 2

        // Reset state
        #12;
        chk("reset_outputs", 32'(outs()), 32'(8'b1000_0000));
        @(negedge clk);
        resetN = 1'b1;

        foreach (tbl[i]) begin
            logic [7:0] req;
            drive(tbl[i].sk, tbl[i].pk, tbl[i].o, tbl[i].t);
            req = {tbl[i].exp[7:1], tbl[i].exp[0] & WARN_ON};
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(req));
        end

        // Stay paused for 20 cycles with tens 0: no strobes, steady warn when enabled.
        drive(1'b0, 1'b0, 4'd5, 4'd0);
        chk("pause_hold_first", 32'(outs()), 32'({7'b1000_100, WARN_ON}));
        for (int k = 1; k < 20; k++) begin
            step();
            chk($sformatf("pause_hold%0d", k), 32'(outs()), 32'({7'b1000_100, WARN_ON}));
        end

        // Resume: prescaler continues from 2, so the first ones strobe is two cycles after resume.
        drive(1'b0, 1'b1, 4'd5, 4'd0);
        chk("resume_running", 32'({running, paused, ones_en_cnt}), 32'(3'b100));
        first_en = -1;
        @(negedge clk);
        pause_key = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (ones_en_cnt && first_en < 0) first_en = k;
        end
        chk("resume_first_enable_delay", 32'(first_en), 32'd2);

        // Start and pause rise together while running: reload wins; held start loads only once.
        drive(1'b1, 1'b1, 4'd5, 4'd0);
        chk("start_over_pause", 32'({load_n, paused}), 32'(2'b00));
        loads      = (load_n == 1'b0) ? 1 : 0;
        saw_paused = paused;
        @(negedge clk);
        pause_key = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
            if (!load_n) loads++;
            saw_paused = saw_paused | paused;
        end
        chk("held_start_single_load", 32'(loads), 32'd1);
        chk("held_start_never_paused", 32'(saw_paused), 32'd0);
        chk("held_start_running", 32'(running), 32'd1);

        // Asynchronous reset mid-run abandons the count and needs a fresh start rise.
        drive(1'b0, 1'b0, 4'd5, 4'd3);
        chk("pre_reset_running", 32'(running), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'(8'b1000_0000));
        @(negedge clk);
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_reset_idle%0d", k), 32'(outs()), 32'(8'b1000_0000));
        end
        drive(1'b1, 1'b0, 4'd5, 4'd3);
        chk("post_reset_start_load", 32'(outs()), 32'(8'b0000_0000));
        drive(1'b0, 1'b0, 4'd5, 4'd3);
        chk("post_reset_running", 32'(outs()), 32'(8'b1001_0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
